// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with pipelined memory requests and a DEPTH-entry {pc, instr} queue.
// Redirects flush the queue and discard all in-flight responses.
module if_fetch_queue #(
  parameter int unsigned         XLEN      = 32,
  parameter int unsigned         DEPTH     = 4,
  parameter logic [XLEN-1:0]     RESET_PC  = '0,
  parameter logic [XLEN-1:0]     NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            if_stall,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_valid
);

  localparam int unsigned PW     = $clog2(DEPTH);
  localparam int unsigned CW     = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW:0]   DepthW = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [XLEN-1:0] fifo_pc_q    [DEPTH];
  logic [XLEN-1:0] fifo_instr_q [DEPTH];
  logic [XLEN-1:0] tag_q        [DEPTH];

  logic [CW:0] credit;
  logic [CW:0] drop_sum;
  logic        req_fire;
  logic        rsp_keep;
  logic        pop;

  assign credit   = {1'b0, count_q} + {1'b0, out_q};
  assign drop_sum = {1'b0, drop_q} + {1'b0, out_q};

  // Credit rule: every issued request is guaranteed a queue slot on return.
  assign imem_req_valid = rst_n && !redirect_valid && (credit < DepthW);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && !redirect_valid && (drop_q == '0);

  assign if_valid = !redirect_valid && (count_q != '0);
  assign instr    = if_valid ? fifo_instr_q[rd_ptr_q] : NOP_INSTR;
  assign if_pc    = if_valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign pop      = if_valid && !if_stall;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    out_d      = out_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;
    if (redirect_valid) begin
      // Tags of dropped requests are discarded here, so drops never pop the tag queue.
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      out_d      = '0;
      drop_d     = CW'(drop_sum - (CW+1)'(imem_rsp_valid));
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      tag_rd_d   = '0;
      tag_wr_d   = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        tag_wr_d   = tag_wr_q + PW'(1);
      end
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (rsp_keep) begin
        tag_rd_d = tag_rd_q + PW'(1);
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(rsp_keep) - CW'(pop);
      out_d   = out_q + CW'(req_fire) - CW'(rsp_keep);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_q[tag_wr_q] <= fetch_pc_q;
    end
    if (rsp_keep) begin
      fifo_pc_q[wr_ptr_q]    <= tag_q[tag_rd_q];
      fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (drop_sum == '0)));
  a_count_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    !(!redirect_valid && rsp_keep && !pop && (count_q == DepthC)));
  a_out_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    !(!redirect_valid && req_fire && !rsp_keep && (out_q == DepthC)));
  a_drop_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    !(redirect_valid && ((drop_sum - (CW+1)'(imem_rsp_valid)) > DepthW)));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: in-order memory model with configurable latency,
// scoreboard of consumed {pc, instr} pairs, and hand-computed cycle checks.
module tb_if_fetch_queue;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] KEY      = 32'h5A5A_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic [31:0] if_pc;
  logic        if_valid;

  if_fetch_queue #(
    .XLEN      (XLEN),
    .DEPTH     (DEPTH),
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_stall       (if_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr          (instr),
    .if_pc          (if_pc),
    .if_valid       (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          cyc;
  int          lat;
  int          n_cons;
  logic [31:0] exp_pc;
  logic [31:0] mem_addr [$];
  int          mem_due  [$];
  logic [31:0] acc_q    [$];

  logic        smp_req_valid;
  logic [31:0] smp_req_addr;
  logic        smp_if_valid;
  logic [31:0] smp_if_pc;
  logic [31:0] smp_instr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge with this cycle's inputs applied; returns at the next falling edge.
  task automatic tick();
    #2;
    smp_req_valid = imem_req_valid;
    smp_req_addr  = imem_req_addr;
    smp_if_valid  = if_valid;
    smp_if_pc     = if_pc;
    smp_instr     = instr;
    if (rst_n) begin
      if (imem_req_valid && imem_req_ready) begin
        mem_addr.push_back(imem_req_addr);
        mem_due.push_back(cyc + lat);
        acc_q.push_back(imem_req_addr);
      end
      if (if_valid) begin
        if (!if_stall) begin
          check_eq("cons_pc", if_pc, exp_pc);
          check_eq("cons_instr", instr, exp_pc ^ KEY);
          exp_pc = exp_pc + 32'd4;
          n_cons++;
        end
      end else begin
        check_eq("idle_instr", instr, NOP);
        check_eq("idle_pc", if_pc, 32'h0);
      end
      if (redirect_valid) exp_pc = redirect_pc;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_addr[0] ^ KEY;
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_stall       = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mem_addr.delete();
    mem_due.delete();
    acc_q.delete();
    exp_pc = RESET_PC;
    n_cons = 0;
    cyc    = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (smp_if_valid) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    lat            = 1;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_stall       = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;

    // Reset state and first fetches with 1-cycle memory
    @(negedge clk);
    #1;
    check_eq("rst_if_valid", if_valid, 0);
    check_eq("rst_instr", instr, NOP);
    check_eq("rst_if_pc", if_pc, 0);
    check_eq("rst_req_valid", imem_req_valid, 0);
    @(negedge clk);
    do_reset();
    lat = 1;
    tick();
    check_eq("c0_req_valid", smp_req_valid, 1);
    check_eq("c0_req_addr", smp_req_addr, 32'h0);
    check_eq("c0_if_valid", smp_if_valid, 0);
    tick();
    check_eq("c1_req_addr", smp_req_addr, 32'h4);
    check_eq("c1_if_valid", smp_if_valid, 0);
    tick();
    check_eq("c2_if_valid", smp_if_valid, 1);
    check_eq("c2_if_pc", smp_if_pc, 32'h0);
    repeat (6) tick();
    check_eq("stream_count", n_cons, 7);

    // Stall from reset: exactly DEPTH requests, then drain back-to-back
    do_reset();
    lat      = 1;
    if_stall = 1'b1;
    repeat (10) tick();
    check_eq("stall_reqs", acc_q.size(), 4);
    check_eq("stall_req_valid", smp_req_valid, 0);
    check_eq("stall_if_valid", smp_if_valid, 1);
    check_eq("stall_head_pc", smp_if_pc, 32'h0);
    if_stall = 1'b0;
    repeat (4) tick();
    check_eq("drain_count", n_cons, 4);
    check_eq("resume_issued", acc_q.size() >= 5, 1);
    if (acc_q.size() >= 5) check_eq("resume_addr", acc_q[4], 32'h10);

    // Redirect with 3 requests in flight (4-cycle memory)
    do_reset();
    lat = 4;
    repeat (3) tick();
    check_eq("inflight_reqs", acc_q.size(), 3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    check_eq("redir_req_valid", smp_req_valid, 0);
    redirect_valid = 1'b0;
    tick();
    check_eq("redir_next_valid", smp_req_valid, 1);
    check_eq("redir_next_addr", smp_req_addr, 32'h100);
    wait_valid(n);
    check_eq("redir_first_lat", n, 5);
    check_eq("redir_first_pc", smp_if_pc, 32'h100);

    // Redirect coinciding with a response and a pop
    do_reset();
    lat = 1;
    repeat (5) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    check_eq("rp_if_valid", smp_if_valid, 0);
    check_eq("rp_instr", smp_instr, NOP);
    check_eq("rp_if_pc", smp_if_pc, 32'h0);
    check_eq("rp_req_valid", smp_req_valid, 0);
    redirect_valid = 1'b0;
    tick();
    check_eq("rp_empty", smp_if_valid, 0);
    check_eq("rp_req_valid2", smp_req_valid, 1);
    check_eq("rp_req_addr2", smp_req_addr, 32'h200);
    tick();
    check_eq("rp_still_empty", smp_if_valid, 0);
    tick();
    check_eq("rp_first_valid", smp_if_valid, 1);
    check_eq("rp_first_pc", smp_if_pc, 32'h200);

    // Back-to-back redirects, last one wins (2-cycle memory)
    do_reset();
    lat = 2;
    repeat (6) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();
    redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    wait_valid(n);
    check_eq("b2b_lat", n, 4);
    check_eq("b2b_pc", smp_if_pc, 32'h400);

    // Fetch address wrap
    do_reset();
    lat            = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    repeat (2) tick();
    check_eq("wrap_reqs", acc_q.size(), 2);
    if (acc_q.size() >= 2) begin
      check_eq("wrap_addr0", acc_q[0], 32'hFFFF_FFFC);
      check_eq("wrap_addr1", acc_q[1], 32'h0);
    end
    repeat (4) tick();
    check_eq("wrap_count", n_cons, 4);

    // Random ready/stall, then asynchronous reset mid-cycle
    do_reset();
    lat = 2;
    for (int i = 0; i < 300; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      if_stall       = ($urandom_range(0, 3) == 0);
      tick();
    end
    check_eq("rand_progress", n_cons >= 40, 1);
    imem_req_ready = 1'b1;
    if_stall       = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_if_valid", if_valid, 0);
    check_eq("arst_instr", instr, NOP);
    check_eq("arst_if_pc", if_pc, 0);
    check_eq("arst_req_valid", imem_req_valid, 0);
    @(negedge clk);
    do_reset();
    lat = 1;
    tick();
    check_eq("arst_restart_n", acc_q.size(), 1);
    if (acc_q.size() >= 1) check_eq("arst_restart_addr", acc_q[0], RESET_PC);
    repeat (5) tick();
    check_eq("arst_count", n_cons, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
